// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for the five-stage RISC-V
// pipeline. Produces the load enables and bubble (flush) controls for the
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, resolving load-use hazards,
// taken-branch flushes and multi-cycle data-memory waits. Also generates the
// EX-stage operand forwarding selects. A small FSM tracks how long a memory
// access has been stalling, freezes the pipeline on timeout, and a counter
// records the number of cycles the PC was held.
//
// Parameters:
//   MEM_TIMEOUT    consecutive memory-stall cycles before ERROR (>= 1)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_rs1, id_rs2                 source registers of the ID instruction
//   id_use_rs1, id_use_rs2         ID instruction really reads rs1/rs2
//   ex_rs1, ex_rs2, ex_rd          EX instruction sources / destination
//   ex_mem_read                    EX instruction is a load
//   ex_branch_taken                branch/jump in EX resolved taken
//   mem_rd, mem_reg_write          EX/MEM destination and write enable
//   mem_req, mem_ready             data-memory request / completion
//   wb_rd, wb_reg_write            MEM/WB destination and write enable
//   pc_en .. mem_wb_en             pipeline register load enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush                   load a bubble at the next edge
//   forward_a, forward_b           00 regfile, 10 EX/MEM, 01 MEM/WB
//   mem_err                        sticky memory-timeout error
//   stall_cycles                   cycles with pc_en=0 since reset

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW:0] TIMEOUT_V = MEM_TIMEOUT[WCW:0];

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_next;
  logic [WCW:0]   wait_cnt_plus;
  logic           mem_stall;
  logic           load_use;

  // Hazard detection. A memory stall only counts while the FSM is live; in
  // ERROR everything is frozen regardless of the memory handshake.
  always_comb begin
    mem_stall = (state != ERROR) & mem_req & ~mem_ready;
    load_use  = ex_mem_read & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) |
                 (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Pipeline controls. Defaults are the frozen pattern, which is exactly what
  // reset and ERROR need; the other cases follow the priority
  // mem_stall > branch > load_use > normal. A memory stall holds the EX
  // instruction, so its branch or load-use hazard is re-evaluated later.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset && state != ERROR) begin
      if (mem_stall) begin
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

  // Forwarding selects. The EX/MEM result is younger than MEM/WB, so it wins
  // when both match; x0 is never forwarded.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!reset) begin
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
        forward_a = 2'b10;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
        forward_a = 2'b01;
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
        forward_b = 2'b10;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
        forward_b = 2'b01;
    end
  end

  // Memory-wait FSM next state. wait_cnt holds the number of stalled cycles
  // already seen in this access; the increment is checked against the
  // timeout before it is stored, so the counter never wraps.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    wait_cnt_plus = {1'b0, wait_cnt} + {{WCW{1'b0}}, 1'b1};
    case (state)
      RUN: begin
        if (mem_stall) begin
          wait_cnt_next = {{(WCW-1){1'b0}}, 1'b1};
          state_next    = (MEM_TIMEOUT == 1) ? ERROR : MWAIT;
        end
      end
      MWAIT: begin
        if (mem_ready || !mem_req) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_plus == TIMEOUT_V) begin
          state_next = ERROR;
        end else begin
          wait_cnt_next = wait_cnt_plus[WCW-1:0];
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // State, sticky error flag and stall-cycle counter. mem_err tracks the
  // registered state so it is high in exactly the cycles spent in ERROR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      mem_err  <= (state_next == ERROR);
      if (!pc_en)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4). Directed
// scenarios from the hazard rules are followed by randomized traffic. The
// reference model keeps only an error flag, a count of consecutive stalled
// memory cycles and the expected stall counter, and derives the expected
// controls directly from the priority rules.

module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]  forward_a, forward_b;
  logic        mem_err;
  logic [31:0] stall_cycles;
  logic [7:0]  obs_ctrl;

  int          n_cmp  = 0;
  int          n_fail = 0;

  bit          m_err;
  int          m_run;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  assign obs_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes}
  function automatic logic [7:0] exp_ctrl();
    bit lu;
    if (reset || m_err) return 8'b00000_000;
    if (mem_req && !mem_ready) return 8'b00001_001;
    if (ex_branch_taken) return 8'b11111_110;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (lu) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (reset) return 2'b00;
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Advance one clock edge and the reference model with it.
  task automatic tick();
    logic [7:0] c;
    c = exp_ctrl();
    @(posedge clk);
    if (reset) begin
      m_err   = 0;
      m_run   = 0;
      m_stall = 32'd0;
    end else begin
      if (!c[7]) m_stall = m_stall + 32'd1;
      if (!m_err && mem_req && !mem_ready) begin
        m_run++;
        if (m_run >= TO) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 0; ex_branch_taken = 0;
    mem_rd = 5'd0; mem_reg_write = 0; mem_req = 0; mem_ready = 0;
    wb_rd = 5'd0; wb_reg_write = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1;
    ex_rs2 = 5'd9; wb_rd = 5'd9; wb_reg_write = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", obs_ctrl, 8'h00);
    end
    n_cmp++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_fwd: got %b/%b expected 00/00", forward_a, forward_b);
    end
    tick();
    reset = 0;
    set_idle();
    #1;
    n_cmp++;
    if (mem_err !== 1'b0 || stall_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got err=%b stalls=%0d expected err=0 stalls=0",
               mem_err, stall_cycles);
    end
    n_cmp++;
    if (obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ctrl: got %b expected %b", obs_ctrl, 8'b11111_000);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    set_idle();
    s0 = m_stall;
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b00111_010) begin
      n_fail++;
      $display("[TB] FAIL load_use_ctrl: got %b expected %b", obs_ctrl, 8'b00111_010);
    end
    tick();
    ex_mem_read = 0;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL load_use_resume: got %b expected %b", obs_ctrl, 8'b11111_000);
    end
    n_cmp++;
    if (stall_cycles !== s0 + 32'd1) begin
      n_fail++;
      $display("[TB] FAIL load_use_stalls: got %0d expected %0d", stall_cycles, s0 + 32'd1);
    end
    // rs2 path, and a load into x0 is no hazard
    ex_mem_read = 1; ex_rd = 5'd12; id_rs1 = 5'd1; id_rs2 = 5'd12;
    id_use_rs1 = 1; id_use_rs2 = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b00111_010) begin
      n_fail++;
      $display("[TB] FAIL load_use_rs2: got %b expected %b", obs_ctrl, 8'b00111_010);
    end
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL load_use_x0: got %b expected %b", obs_ctrl, 8'b11111_000);
    end
    tick();
  endtask

  task automatic test_branch_load_use();
    logic [31:0] s0;
    set_idle();
    s0 = m_stall;
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    ex_branch_taken = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_110) begin
      n_fail++;
      $display("[TB] FAIL branch_ctrl: got %b expected %b", obs_ctrl, 8'b11111_110);
    end
    tick();
    set_idle();
    #1;
    n_cmp++;
    if (stall_cycles !== s0) begin
      n_fail++;
      $display("[TB] FAIL branch_stalls: got %0d expected %0d", stall_cycles, s0);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    set_idle();
    s0 = m_stall;
    mem_req = 1; mem_ready = 0;
    ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs_ctrl !== 8'b00001_001) begin
        n_fail++;
        $display("[TB] FAIL mem_wait_ctrl[%0d]: got %b expected %b", i, obs_ctrl, 8'b00001_001);
      end
      tick();
    end
    mem_ready = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_110) begin
      n_fail++;
      $display("[TB] FAIL mem_wait_release: got %b expected %b", obs_ctrl, 8'b11111_110);
    end
    tick();
    set_idle();
    #1;
    n_cmp++;
    if (stall_cycles !== s0 + 32'd3 || mem_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mem_wait_stalls: got %0d err=%b expected %0d err=0",
               stall_cycles, mem_err, s0 + 32'd3);
    end
    // ready in the same cycle as the request: no stall at all
    mem_req = 1; mem_ready = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL mem_ready_same_cycle: got %b expected %b", obs_ctrl, 8'b11111_000);
    end
    tick();
    set_idle();
  endtask

  task automatic test_timeout();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      n_cmp++;
      if (obs_ctrl !== ((i < TO) ? 8'b00001_001 : 8'b00000_000)) begin
        n_fail++;
        $display("[TB] FAIL timeout_ctrl[%0d]: got %b expected %b", i, obs_ctrl,
                 (i < TO) ? 8'b00001_001 : 8'b00000_000);
      end
      n_cmp++;
      if (mem_err !== (i >= TO)) begin
        n_fail++;
        $display("[TB] FAIL timeout_err[%0d]: got %b expected %b", i, mem_err, (i >= TO));
      end
      tick();
    end
    // the pipeline stays frozen even once memory answers
    mem_ready = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'h00 || stall_cycles !== 32'd7) begin
      n_fail++;
      $display("[TB] FAIL timeout_frozen: got ctrl=%b stalls=%0d expected ctrl=00000000 stalls=7",
               obs_ctrl, stall_cycles);
    end
    reset = 1;
    tick();
    reset = 0;
    set_idle();
    #1;
    n_cmp++;
    if (mem_err !== 1'b0 || stall_cycles !== 32'd0 || obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL timeout_reset: got err=%b stalls=%0d ctrl=%b expected err=0 stalls=0 ctrl=11111000",
               mem_err, stall_cycles, obs_ctrl);
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1; wb_rd = 5'd3; wb_reg_write = 1;
    #1;
    n_cmp++;
    if (forward_a !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL fwd_both: got %b expected 10", forward_a);
    end
    mem_rd = 5'd0;
    #1;
    n_cmp++;
    if (forward_a !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL fwd_wb: got %b expected 01", forward_a);
    end
    ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    n_cmp++;
    if (forward_b !== 2'b00 || forward_a !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL fwd_x0: got %b/%b expected 00/00", forward_a, forward_b);
    end
    ex_rs2 = 5'd8; wb_rd = 5'd8; mem_rd = 5'd8; mem_reg_write = 0;
    #1;
    n_cmp++;
    if (forward_b !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL fwd_b_wb: got %b expected 01", forward_b);
    end
    tick();
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    reset = 1;
    ex_rs1 = 5'd4; mem_rd = 5'd4; mem_reg_write = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'h00 || forward_a !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_reset: got ctrl=%b fa=%b expected 00000000/00",
               obs_ctrl, forward_a);
    end
    tick();
    reset = 0;
    mem_ready = 1;
    #1;
    n_cmp++;
    if (obs_ctrl !== 8'b11111_000 || mem_err !== 1'b0 || stall_cycles !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_resume: got ctrl=%b err=%b stalls=%0d expected 11111000/0/0",
               obs_ctrl, mem_err, stall_cycles);
    end
    tick();
    // a fresh wait of TO-1 cycles must not time out
    mem_ready = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    mem_ready = 1;
    #1;
    n_cmp++;
    if (mem_err !== 1'b0 || obs_ctrl !== 8'b11111_000) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_no_residual: got err=%b ctrl=%b expected 0/11111000",
               mem_err, obs_ctrl);
    end
    tick();
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 39) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_rs1          = 5'($urandom_range(0, 3));
      ex_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_rd          = 5'($urandom_range(0, 3));
      mem_reg_write   = 1'($urandom_range(0, 1));
      wb_rd           = 5'($urandom_range(0, 3));
      wb_reg_write    = 1'($urandom_range(0, 1));
      mem_req         = ($urandom_range(0, 2) != 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
      #1;
      n_cmp++;
      if (obs_ctrl !== exp_ctrl()) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl[%0d]: got %b expected %b", i, obs_ctrl, exp_ctrl());
      end
      n_cmp++;
      if (forward_a !== exp_fwd(ex_rs1) || forward_b !== exp_fwd(ex_rs2)) begin
        n_fail++;
        $display("[TB] FAIL rand_fwd[%0d]: got %b/%b expected %b/%b", i,
                 forward_a, forward_b, exp_fwd(ex_rs1), exp_fwd(ex_rs2));
      end
      n_cmp++;
      if (mem_err !== m_err || stall_cycles !== m_stall) begin
        n_fail++;
        $display("[TB] FAIL rand_state[%0d]: got err=%b stalls=%0d expected err=%b stalls=%0d",
                 i, mem_err, stall_cycles, m_err, m_stall);
      end
      tick();
    end
    reset = 0;
    set_idle();
  endtask

  initial begin
    m_err   = 0;
    m_run   = 0;
    m_stall = 32'd0;
    reset   = 1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the enable/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, and generates EX-stage forwarding selects. A small FSM tracks memory wait duration, enforces a timeout, and maintains a stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-stall cycles before entering ERROR (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX
- ex_rd  in  5  destination register in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_rd  in  5  EX/MEM destination register
- mem_reg_write  in  1  EX/MEM writes the register file
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- wb_rd  in  5  MEM/WB destination register
- wb_reg_write  in  1  MEM/WB writes the register file
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (all-zero control) next edge
- forward_a, forward_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_err  out  1  sticky memory-timeout error
- stall_cycles  out  32  count of cycles with pc_en=0 since reset

## Operation
- FSM states: RUN, MWAIT, ERROR. The reset state is RUN, with wait_cnt=0.
- mem_stall = mem_req & ~mem_ready (in RUN or MWAIT).
- load_use = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from state and inputs. Priority is ERROR > mem_stall > branch > load_use > normal.
  - ERROR: all enables 0, all flushes 0. The pipeline is frozen until reset.
  - mem_stall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1 and mem_wb_flush=1 (bubble to WB). Branch and load-use actions are suppressed because the EX instruction is held and re-evaluated.
  - ex_branch_taken: all enables 1; if_id_flush=1, id_ex_flush=1. This overrides load_use because the ID instruction is wrong-path.
  - load_use: pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1; ex_mem_en, mem_wb_en = 1.
  - normal: all enables 1, all flushes 0.
- Forwarding is computed identically for operand A (ex_rs1) and operand B (ex_rs2):
  - 10 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rsX.
  - Otherwise 01 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rsX.
  - Otherwise 00. EX/MEM wins when both match.
- FSM transitions at each edge:
  - RUN: mem_stall → MWAIT with wait_cnt=1, or → ERROR if MEM_TIMEOUT==1. Otherwise stays in RUN.
  - MWAIT, mem_ready=1 or mem_req=0: → RUN, wait_cnt=0.
  - MWAIT, still stalled: if wait_cnt+1==MEM_TIMEOUT → ERROR; else wait_cnt++.
  - ERROR: stays in ERROR; only reset exits.
- wait_cnt width is $clog2(MEM_TIMEOUT+1) and it never wraps.
- mem_err is registered and equals 1 in every cycle the state is ERROR.
- stall_cycles increments (modulo 2^32) at each edge where pc_en=0 and reset=0.

## Timing
- While reset=1: all enables 0, all flushes 0, forward_a and forward_b = 00 (combinationally forced). At the next edge: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
- Reset mid-stall or in ERROR returns the block to RUN at the next edge with no residual stall.
- Control and forwarding outputs have zero-cycle latency (same-cycle combinational). mem_err and stall_cycles update one edge after their cause.
- Load-use costs exactly one stall cycle: next cycle, the load is in MEM and ex_mem_read for the ID instruction is no longer set.
- A memory access with mem_ready low for N cycles (N<MEM_TIMEOUT) stalls exactly N cycles. The pipeline advances in the cycle mem_ready=1.
- mem_ready=1 in the same cycle as mem_req causes no stall and no state change.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cycles goes from 0 to 1.
- Branch during load-use: the same inputs plus ex_branch_taken=1 → pc_en=1, if_id_flush=1, id_ex_flush=1, stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → pc_en=0 for exactly 3 cycles, mem_wb_flush=1 on those cycles; FSM RUN→MWAIT→MWAIT→MWAIT→RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → ERROR from cycle 4, mem_err=1, all enables 0. Reset → RUN, mem_err=0, stall_cycles=0.
- Forwarding: ex_rs1=3, mem_rd=3/mem_reg_write=1 and wb_rd=3/wb_reg_write=1 → forward_a=10. With mem_rd=0 → forward_a=01. Register x0 never forwards (ex_rs2=0 with a matching rd=0 → forward_b=00).
- Reset during mem_stall with wait_cnt=2: assert reset one cycle → outputs forced low that cycle; then RUN, wait_cnt=0, and with mem_ready=1 normal enables resume.
